// File: rtl/seq_sched_pkg.sv
// Shared types and defaults for the time-shared sequence detector scheduler.
package seq_sched_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int FRAME_W_DEF = 8;
  localparam int CNT_W_DEF   = 4;
  localparam int DET_LAT_DEF = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    SHIFT  = 3'd2,
    DRAIN  = 3'd3,
    REPORT = 3'd4
  } state_t;

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_det_sched_if.sv
// Client-side request/grant/result bundle of the detector scheduler.
interface seq_det_sched_if
  import seq_sched_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int ID_W    = id_w(NREQ)
) ();

  logic [NREQ-1:0]         req;
  logic [NREQ*FRAME_W-1:0] frame_data;
  logic [NREQ-1:0]         grant;
  logic                    busy;
  logic                    done;
  logic [ID_W-1:0]         done_id;
  logic [CNT_W-1:0]        match_cnt;

  modport master (
    output req, frame_data,
    input  grant, busy, done, done_id, match_cnt
  );

  modport slave (
    input  req, frame_data,
    output grant, busy, done, done_id, match_cnt
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
  import seq_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int ID_W = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one serial sequence detector among NREQ clients;
// shifts the granted frame MSB-first and reports the saturated hit count.
module seq_det_sched
  import seq_sched_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DET_LAT = DET_LAT_DEF
) (
  input  logic               clock,
  input  logic               res,
  seq_det_sched_if.slave     host,
  output logic               det_in,
  output logic               det_res,
  input  logic               det_o
);

  localparam int ID_W       = id_w(NREQ);
  localparam int CYC_W      = $clog2(FRAME_W + DET_LAT + 1);
  localparam int LAST_SHIFT = FRAME_W - 1;
  localparam int LAST_CYC   = FRAME_W + DET_LAT - 1;

  state_t             state, state_nx;
  logic [ID_W-1:0]    ptr;
  logic [CYC_W-1:0]   cyc;
  logic [CNT_W-1:0]   hit, hit_nx;
  logic [NREQ-1:0]    grant_q;
  logic [ID_W-1:0]    done_id_q;
  logic [CNT_W-1:0]   match_q;
  logic [FRAME_W-1:0] frame_q;
  logic [ID_W-1:0]    id_q;
  logic               sample;

  logic [NREQ-1:0]    arb_gnt;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req (host.req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // cyc runs across SHIFT and DRAIN so the hit window is a single compare
  always_comb begin
    state_nx = state;
    det_res  = 1'b1;
    det_in   = 1'b0;
    sample   = 1'b0;
    case (state)
      IDLE:   if (arb_any) state_nx = CLR;
      CLR:    state_nx = SHIFT;
      SHIFT: begin
        det_res = 1'b0;
        det_in  = frame_q[FRAME_W-1];
        sample  = (int'(cyc) >= DET_LAT);
        if (int'(cyc) == LAST_SHIFT) state_nx = (DET_LAT > 0) ? DRAIN : REPORT;
      end
      DRAIN: begin
        det_res = 1'b0;
        sample  = (int'(cyc) >= DET_LAT);
        if (int'(cyc) == LAST_CYC) state_nx = REPORT;
      end
      REPORT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    hit_nx = (sample && det_o) ? sat_inc(hit) : hit;
  end

  always_ff @(posedge clock) begin
    if (!res) begin
      state     <= IDLE;
      ptr       <= '0;
      cyc       <= '0;
      hit       <= '0;
      grant_q   <= '0;
      done_id_q <= '0;
      match_q   <= '0;
    end else begin
      state   <= state_nx;
      grant_q <= (state == IDLE) ? arb_gnt : '0;
      case (state)
        CLR: begin
          cyc <= '0;
          hit <= '0;
        end
        SHIFT, DRAIN: begin
          cyc <= cyc + CYC_W'(1);
          hit <= hit_nx;
          // final window sample lands on the same edge that enters REPORT
          if (state_nx == REPORT) begin
            done_id_q <= id_q;
            match_q   <= hit_nx;
          end
        end
        REPORT: ptr <= (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + ID_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (state == IDLE && arb_any) begin
      frame_q <= host.frame_data[int'(arb_idx) * FRAME_W +: FRAME_W];
      id_q    <= arb_idx;
    end else if (state == SHIFT) begin
      frame_q <= {frame_q[FRAME_W-2:0], 1'b0};
    end
  end

  assign host.grant     = grant_q;
  assign host.busy      = (state != IDLE);
  assign host.done      = (state == REPORT);
  assign host.done_id   = done_id_q;
  assign host.match_cnt = match_q;

endmodule
